deoxys_round_ctrl: RTL and testbench
====================================

DEOXYS_ROUND_CTRL -- requirements
Module: deoxys_round_ctrl

Interface
REQ-001 The block SHALL have parameter RNDS_PER_CLK, default 1: rounds computed per RUN cycle; it equals the round-constant generator's RNDS_PER_CLK.
REQ-002 The block SHALL have parameter NUM_RNDS, default 16: total rounds per block; NUM_RNDS mod RNDS_PER_CLK = 0; NUM_RNDS <= 16.
REQ-003 The block SHALL derive the local constant STEPS = NUM_RNDS/RNDS_PER_CLK.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port start_i, input, 1 bit: request for a new block operation.
REQ-007 The block SHALL have port dec_i, input, 1 bit: direction (1 = decrypt), sampled when start is accepted.
REQ-008 The block SHALL have port ready_o, output, 1 bit: able to accept start_i.
REQ-009 The block SHALL have port load_o, output, 1 bit: load state/tweakey registers this cycle.
REQ-010 The block SHALL have port en_o, output, 1 bit: round-datapath enable.
REQ-011 The block SHALL have port cnt_o, output, 6 bits: step index driven to the constant generator's cnt input.
REQ-012 The block SHALL have port first_o, output, 1 bit: first RUN cycle.
REQ-013 The block SHALL have port last_o, output, 1 bit: final RUN cycle.
REQ-014 The block SHALL have port dec_o, output, 1 bit: latched direction.
REQ-015 The block SHALL have port valid_o, output, 1 bit: result available.
REQ-016 The block SHALL have port ready_i, input, 1 bit: consumer accepts the result.
REQ-017 The block SHALL have port abort_i, input, 1 bit, present only when DEOXYS_CTRL_ABORT_EN is defined: cancel the operation in progress.

Function
REQ-018 The block SHALL implement an FSM with states IDLE, LOAD, RUN and DONE, and all outputs SHALL be decoded from registered state only.
REQ-019 In IDLE, ready_o SHALL be 1; when start_i=1, the block SHALL latch dec_i into dec_o and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-020 LOAD SHALL last exactly 1 cycle with load_o=1 and en_o=0, then go to RUN.
REQ-021 On the LOAD->RUN transition, cnt SHALL be set to 0 when encrypting and to STEPS-1 when decrypting.
REQ-022 RUN SHALL last exactly STEPS cycles with en_o=1.
REQ-023 In RUN, cnt SHALL increment by 1 per cycle when encrypting and decrement by 1 per cycle when decrypting.
REQ-024 first_o SHALL be 1 only in the first RUN cycle.
REQ-025 last_o SHALL be 1 only in the STEPS-th RUN cycle, when cnt_o = STEPS-1 (encrypt) or 0 (decrypt); after that cycle the block SHALL go to DONE.
REQ-026 When STEPS=1, first_o and last_o SHALL both be 1 in the single RUN cycle.
REQ-027 cnt SHALL never wrap: it SHALL stay within 0..STEPS-1, and SHALL hold its value outside RUN.
REQ-028 In DONE, valid_o SHALL be 1 and SHALL stay 1 until ready_i=1; on that handshake cycle the block SHALL go to IDLE.
REQ-029 start_i SHALL be ignored in every state except IDLE; there is no back-to-back pipelining.
REQ-030 Latency: with start accepted at edge T, load_o SHALL be 1 in cycle T+1, RUN SHALL occupy T+2..T+1+STEPS, and valid_o SHALL first be 1 at T+2+STEPS.
REQ-031 ready_o, load_o, en_o, first_o, last_o and valid_o SHALL be mutually consistent with the state: exactly one of ready_o, load_o, en_o, valid_o SHALL be 1 in any cycle.

Reset
REQ-032 When rst_n=0 at a rising edge, the block SHALL enter IDLE with cnt=0 and dec_o=0, from any state, including mid-RUN and DONE.
REQ-033 After reset: ready_o=1, and load_o, en_o, first_o, last_o and valid_o SHALL be 0.
REQ-034 A result pending in DONE SHALL be discarded by reset.

Configuration
REQ-035 When DEOXYS_CTRL_ABORT_EN is defined, abort_i=1 in LOAD or RUN SHALL force IDLE at the next edge and set cnt=0, and valid_o SHALL NOT assert for that block.
REQ-036 When DEOXYS_CTRL_ABORT_EN is defined, abort_i SHALL be ignored in IDLE and DONE.
REQ-037 When DEOXYS_CTRL_ABORT_EN is undefined, port abort_i SHALL be absent and behaviour SHALL be identical to abort_i tied to 0.

Verification
REQ-038 Encrypt test: defaults, start_i=1, dec_i=0 in IDLE -> load_o 1 cycle; cnt_o 0,1,...,15 over 16 en_o cycles; first_o at cnt 0, last_o at cnt 15; valid_o at T+18.
REQ-039 Decrypt test: defaults, dec_i=1 -> cnt_o 15 down to 0; last_o at cnt 0; dec_o=1 throughout.
REQ-040 Backpressure test: hold ready_i=0 for 5 cycles in DONE -> valid_o held 5+ cycles; a start_i during that time is ignored; IDLE follows the cycle after ready_i=1.
REQ-041 Reset test: rst_n=0 at cnt_o=7 of RUN -> next cycle IDLE, ready_o=1, cnt_o=0, and no valid_o.
REQ-042 Multi-round test: RNDS_PER_CLK=4, NUM_RNDS=16 -> STEPS=4; cnt_o 0..3; valid_o at T+6.
REQ-043 Abort test (macro defined): abort_i=1 at cnt_o=3 -> IDLE next cycle, valid_o never asserts; a new start then completes normally.

Source files
------------

// File: rtl/deoxys_round_ctrl.sv
// deoxys_round_ctrl -- sequencing FSM for an iterative Deoxys round datapath.
//
// Walks a block operation through IDLE -> LOAD -> RUN -> DONE. It produces the
// load and enable strobes for the state/tweakey registers and the step index
// for the round-constant generator, and holds the result until it is consumed.
// Encryption counts the step index up. Decryption counts it down, so the
// constant generator replays the same constants in reverse order.
//
// Optional feature: define DEOXYS_CTRL_ABORT_EN to add the abort_i port. That
// port cancels an operation that is in LOAD or RUN. When the macro is not
// defined the port is absent and the block behaves as if abort were held at 0.

module deoxys_round_ctrl #(
    parameter int RNDS_PER_CLK = 1,
    parameter int NUM_RNDS     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       dec_i,
    output logic       ready_o,
    output logic       load_o,
    output logic       en_o,
    output logic [5:0] cnt_o,
    output logic       first_o,
    output logic       last_o,
    output logic       dec_o,
    output logic       valid_o,
    input  logic       ready_i
`ifdef DEOXYS_CTRL_ABORT_EN
    ,
    input  logic       abort_i
`endif
);

    // Each RUN cycle computes RNDS_PER_CLK rounds, so a block takes STEPS
    // RUN cycles. The step index therefore lives in 0..STEPS-1.
    localparam int         STEPS    = NUM_RNDS / RNDS_PER_CLK;
    localparam logic [5:0] LAST_IDX = 6'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ctrlState_t;

    ctrlState_t state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       dec_q, dec_d;
    logic       firstRun_q, firstRun_d;

    logic       abortReq;
    logic       runLast;

    // Without the abort feature the cancel request is tied off, so the FSM
    // below is the same in both builds.
`ifdef DEOXYS_CTRL_ABORT_EN
    assign abortReq = abort_i;
`else
    assign abortReq = 1'b0;
`endif

    // The final RUN step is recognised from the registered index alone.
    // Encryption ends on the top index and decryption ends on zero. When STEPS
    // is 1, both cases fall on the single RUN cycle.
    assign runLast = (state_q == RUN) &&
                     (dec_q ? (cnt_q == 6'd0) : (cnt_q == LAST_IDX));

    // Next-state logic. The step index only moves inside RUN and stops on
    // the final step instead of wrapping. Outside RUN it holds its value,
    // except on a cancel, which clears it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dec_d      = dec_q;
        firstRun_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    dec_d   = dec_i;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                if (abortReq) begin
                    cnt_d   = 6'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d      = dec_q ? LAST_IDX : 6'd0;
                    firstRun_d = 1'b1;
                    state_d    = RUN;
                end
            end

            RUN: begin
                if (abortReq) begin
                    cnt_d   = 6'd0;
                    state_d = IDLE;
                end else if (runLast) begin
                    state_d = DONE;
                end else begin
                    cnt_d = dec_q ? (cnt_q - 6'd1) : (cnt_q + 6'd1);
                end
            end

            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. The synchronous reset drops any operation in
    // progress, including a result still waiting in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            dec_q      <= 1'b0;
            firstRun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dec_q      <= dec_d;
            firstRun_q <= firstRun_d;
        end
    end

    // Every output is decoded from registered state. Exactly one of
    // ready/load/en/valid is high in any cycle.
    assign ready_o = (state_q == IDLE);
    assign load_o  = (state_q == LOAD);
    assign en_o    = (state_q == RUN);
    assign valid_o = (state_q == DONE);
    assign first_o = (state_q == RUN) && firstRun_q;
    assign last_o  = runLast;
    assign cnt_o   = cnt_q;
    assign dec_o   = dec_q;

endmodule

// File: tb/tb_deoxys_round_ctrl.sv
// tb_deoxys_round_ctrl -- directed bench for deoxys_round_ctrl.
// Drives a default instance (16 steps) and a 4-rounds-per-clock instance
// (4 steps) from one clock. Abort cases are included when
// DEOXYS_CTRL_ABORT_EN is defined.

module tb_deoxys_round_ctrl;

    logic       clk;
    logic       rst_n;
    logic       startIn;
    logic       start4In;
    logic       decIn;
    logic       readyIn;
`ifdef DEOXYS_CTRL_ABORT_EN
    logic       abortIn;
`endif

    logic       readyOut, loadOut, enOut, firstOut, lastOut, decOut, validOut;
    logic [5:0] cntOut;
    logic       ready4Out, load4Out, en4Out, first4Out, last4Out, dec4Out, valid4Out;
    logic [5:0] cnt4Out;

    int compareCount;
    int mismatchCount;

    deoxys_round_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (startIn),
        .dec_i   (decIn),
        .ready_o (readyOut),
        .load_o  (loadOut),
        .en_o    (enOut),
        .cnt_o   (cntOut),
        .first_o (firstOut),
        .last_o  (lastOut),
        .dec_o   (decOut),
        .valid_o (validOut),
        .ready_i (readyIn)
`ifdef DEOXYS_CTRL_ABORT_EN
        ,
        .abort_i (abortIn)
`endif
    );

    deoxys_round_ctrl #(.RNDS_PER_CLK(4), .NUM_RNDS(16)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start4In),
        .dec_i   (decIn),
        .ready_o (ready4Out),
        .load_o  (load4Out),
        .en_o    (en4Out),
        .cnt_o   (cnt4Out),
        .first_o (first4Out),
        .last_o  (last4Out),
        .dec_o   (dec4Out),
        .valid_o (valid4Out),
        .ready_i (readyIn)
`ifdef DEOXYS_CTRL_ABORT_EN
        ,
        .abort_i (1'b0)
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Set the shared request inputs of the default instance.
    task automatic applyStimulus(input logic start, input logic dec, input logic rdy);
        startIn = start;
        decIn   = dec;
        readyIn = rdy;
    endtask

    // Advance one clock. Sampling and driving happen 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run a full block on the default instance with the consumer always ready.
    task automatic runBlock(input logic dec);
        logic [5:0] expCnt;
        applyStimulus(1'b1, dec, 1'b1);
        tick();
        checkOutput("load_pulse", {7'd0, loadOut}, 8'd1);
        checkOutput("load_no_en", {7'd0, enOut}, 8'd0);
        checkOutput("load_not_ready", {7'd0, readyOut}, 8'd0);
        checkOutput("dec_latched", {7'd0, decOut}, {7'd0, dec});
        applyStimulus(1'b0, ~dec, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tick();
            expCnt = dec ? 6'(15 - i) : 6'(i);
            checkOutput("run_en", {7'd0, enOut}, 8'd1);
            checkOutput("run_cnt", {2'd0, cntOut}, {2'd0, expCnt});
            checkOutput("run_first", {7'd0, firstOut}, (i == 0) ? 8'd1 : 8'd0);
            checkOutput("run_last", {7'd0, lastOut}, (i == 15) ? 8'd1 : 8'd0);
            checkOutput("run_dec", {7'd0, decOut}, {7'd0, dec});
        end
        tick();
        checkOutput("done_valid", {7'd0, validOut}, 8'd1);
        checkOutput("done_no_en", {7'd0, enOut}, 8'd0);
        checkOutput("done_cnt_hold", {2'd0, cntOut}, dec ? 8'd0 : 8'd15);
        tick();
        checkOutput("back_idle", {7'd0, readyOut}, 8'd1);
        checkOutput("back_idle_valid", {7'd0, validOut}, 8'd0);
    endtask

    // Main directed sequence.
    initial begin
        logic sawValid;
        compareCount  = 0;
        mismatchCount = 0;
        rst_n    = 1'b0;
        start4In = 1'b0;
`ifdef DEOXYS_CTRL_ABORT_EN
        abortIn  = 1'b0;
`endif
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state.
        checkOutput("rst_ready", {7'd0, readyOut}, 8'd1);
        checkOutput("rst_load", {7'd0, loadOut}, 8'd0);
        checkOutput("rst_en", {7'd0, enOut}, 8'd0);
        checkOutput("rst_first", {7'd0, firstOut}, 8'd0);
        checkOutput("rst_last", {7'd0, lastOut}, 8'd0);
        checkOutput("rst_valid", {7'd0, validOut}, 8'd0);
        checkOutput("rst_cnt", {2'd0, cntOut}, 8'd0);
        checkOutput("rst_dec", {7'd0, decOut}, 8'd0);

        // Idle without start stays idle.
        tick();
        checkOutput("idle_hold", {7'd0, readyOut}, 8'd1);

        // Encrypt, then decrypt.
        runBlock(1'b0);
        runBlock(1'b1);

        // Backpressure: the result waits in DONE and a start there is ignored.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) tick();
        tick();
        checkOutput("bp_valid_first", {7'd0, validOut}, 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_valid_held", {7'd0, validOut}, 8'd1);
            checkOutput("bp_no_load", {7'd0, loadOut}, 8'd0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("bp_idle_ready", {7'd0, readyOut}, 8'd1);
        checkOutput("bp_idle_valid", {7'd0, validOut}, 8'd0);
        checkOutput("bp_start_ignored", {7'd0, loadOut}, 8'd0);
        checkOutput("bp_dec_unchanged", {7'd0, decOut}, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();

        // Reset in the middle of RUN.
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("mid_cnt7", {2'd0, cntOut}, 8'd7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("mid_rst_ready", {7'd0, readyOut}, 8'd1);
        checkOutput("mid_rst_cnt", {2'd0, cntOut}, 8'd0);
        checkOutput("mid_rst_en", {7'd0, enOut}, 8'd0);
        sawValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (validOut) sawValid = 1'b1;
        end
        checkOutput("mid_rst_no_valid", {7'd0, sawValid}, 8'd0);

        // Four rounds per clock: 4 steps, valid at T+6.
        decIn    = 1'b0;
        readyIn  = 1'b1;
        start4In = 1'b1;
        tick();
        start4In = 1'b0;
        checkOutput("m4_load", {7'd0, load4Out}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("m4_en", {7'd0, en4Out}, 8'd1);
            checkOutput("m4_cnt", {2'd0, cnt4Out}, 8'(i));
            checkOutput("m4_first", {7'd0, first4Out}, (i == 0) ? 8'd1 : 8'd0);
            checkOutput("m4_last", {7'd0, last4Out}, (i == 3) ? 8'd1 : 8'd0);
        end
        tick();
        checkOutput("m4_valid", {7'd0, valid4Out}, 8'd1);
        tick();
        checkOutput("m4_idle", {7'd0, ready4Out}, 8'd1);

`ifdef DEOXYS_CTRL_ABORT_EN
        // Abort at step 3: back to IDLE with no result, then a normal block.
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("ab_cnt3", {2'd0, cntOut}, 8'd3);
        abortIn = 1'b1;
        tick();
        abortIn = 1'b0;
        checkOutput("ab_ready", {7'd0, readyOut}, 8'd1);
        checkOutput("ab_cnt0", {2'd0, cntOut}, 8'd0);
        sawValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (validOut) sawValid = 1'b1;
        end
        checkOutput("ab_no_valid", {7'd0, sawValid}, 8'd0);
        runBlock(1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
